// File: rtl/bcd_round_arbiter.sv
// Round-robin arbiter sharing one BCD rounding unit between two requesters.
// The winner's operand is issued, the result (or a timeout marker) is returned.
module bcd_round_arbiter #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [23:0]      bcd0,
  input  logic             req1,
  input  logic [23:0]      bcd1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [19:0]      res_data,
  output logic             res_valid0,
  output logic             res_valid1,
  output logic             res_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             ru_start,
  output logic [23:0]      ru_bcd_in,
  input  logic [19:0]      ru_bcd_out,
  input  logic             ru_done
);

  localparam int unsigned   TW     = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  state_t        state_nx;
  logic          owner;
  logic          owner_nx;
  logic          ptr;
  logic [TW-1:0] timer;
  logic          grant;
  logic          finish;
  logic          expire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    case (state)
      IDLE: begin
        if (req0 && (!req1 || !ptr)) begin
          owner_nx = 1'b0;
          state_nx = ISSUE;
        end else if (req1) begin
          owner_nx = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (ru_done || timer == T_LAST) begin
          state_nx = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Pulses are registered one edge early so they line up with the ISSUE/RESP cycles.
  always_comb begin
    grant  = (state == IDLE) && (state_nx == ISSUE);
    finish = (state == WAIT) && (state_nx == RESP);
    expire = finish && !ru_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= 1'b0;
      ptr        <= 1'b0;
      timer      <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      ru_start   <= 1'b0;
      ru_bcd_in  <= '0;
      res_valid0 <= 1'b0;
      res_valid1 <= 1'b0;
      res_err    <= 1'b0;
      res_data   <= '0;
      err_cnt    <= '0;
    end else begin
      owner      <= owner_nx;
      gnt0       <= grant && !owner_nx;
      gnt1       <= grant && owner_nx;
      ru_start   <= grant;
      res_valid0 <= finish && !owner;
      res_valid1 <= finish && owner;
      res_err    <= expire;
      if (grant) begin
        ru_bcd_in <= owner_nx ? bcd1 : bcd0;
      end
      if (state == ISSUE) begin
        timer <= '0;
      end else if (state == WAIT) begin
        timer <= timer + 1'b1;
      end
      if (finish) begin
        res_data <= expire ? '1 : ru_bcd_out;
      end
      if (expire && err_cnt != '1) begin
        err_cnt <= err_cnt + 1'b1;
      end
      if (state == RESP) begin
        ptr <= ~owner;
      end
    end
  end

endmodule
